// File: rtl/alignment_scorer_pkg.sv
// alignment_scorer_pkg: shared result codes, reason encodings, FSM states and default scoring constants
package alignment_scorer_pkg;
  localparam int DEF_SCORE_W      = 16;
  localparam int DEF_LEN_W        = 12;
  localparam int DEF_MATCH_SCORE  = 2;
  localparam int DEF_MISMATCH_PEN = 3;
  localparam int DEF_GAP_PEN      = 5;
  localparam int DEF_GAP_EXT_PEN  = 2;
  localparam int DEF_X_DROP       = 10;
  localparam logic [2:0] RES_MATCH    = 3'b100;
  localparam logic [2:0] RES_MISMATCH = 3'b010;
  localparam logic [2:0] RES_GAP      = 3'b001;
  typedef enum logic [1:0] {
    REASON_NONE  = 2'b00,
    REASON_LAST  = 2'b01,
    REASON_XDROP = 2'b10,
    REASON_LEN   = 2'b11
  } reason_e;
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_e;
endpackage

// File: rtl/alignment_scorer_sat_add.sv
// score_sat_add: combinational signed saturating adder (a_i + b_i -> sum_o, clamped to W-bit signed range)
module score_sat_add #(
  parameter int W = 16
) (
  input  logic signed [W-1:0] a_i,
  input  logic signed [W-1:0] b_i,
  output logic signed [W-1:0] sum_o
);
  logic signed [W:0] s;
  assign s = {a_i[W-1], a_i} + {b_i[W-1], b_i};
  assign sum_o = (s[W] == s[W-1]) ? s[W-1:0]
               : s[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
endmodule

// File: rtl/alignment_scorer.sv
// alignment_scorer: seed-extension scorer over one-hot compare beats (clk/rst, start, in_valid/in_ready, result, last -> busy, done, best_score, best_len, reason, code_err); affine gaps under SCORER_AFFINE_GAP_EN
module alignment_scorer
  import alignment_scorer_pkg::*;
#(
  parameter int SCORE_W      = DEF_SCORE_W,
  parameter int LEN_W        = DEF_LEN_W,
  parameter int MATCH_SCORE  = DEF_MATCH_SCORE,
  parameter int MISMATCH_PEN = DEF_MISMATCH_PEN,
  parameter int GAP_PEN      = DEF_GAP_PEN,
`ifdef SCORER_AFFINE_GAP_EN
  parameter int GAP_EXT_PEN  = DEF_GAP_EXT_PEN,
`endif
  parameter int X_DROP       = DEF_X_DROP
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         result,
  input  logic               last,
  output logic               busy,
  output logic               done,
  output logic [SCORE_W-1:0] best_score,
  output logic [LEN_W-1:0]   best_len,
  output logic [1:0]         reason,
  output logic               code_err
);
  state_e                    state_q;
  reason_e                   reason_q, term_d;
  logic signed [SCORE_W-1:0] run_q, run_d, best_q, best_d, delta;
  logic signed [SCORE_W:0]   drop;
  logic [LEN_W-1:0]          len_q, len_d, best_len_q;
  logic                      in_ready_q, busy_q, done_q, code_err_q;
  logic                      accept, is_match, is_mis, is_gap, illegal;
`ifdef SCORER_AFFINE_GAP_EN
  logic                      gap_q;
`endif
  assign accept   = in_valid && in_ready_q;
  assign is_match = result == RES_MATCH;
  assign is_mis   = result == RES_MISMATCH;
  assign is_gap   = !is_match && !is_mis;
  assign illegal  = is_gap && result != RES_GAP;
`ifdef SCORER_AFFINE_GAP_EN
  assign delta = is_match ? SCORE_W'(MATCH_SCORE)
               : is_mis   ? SCORE_W'(-MISMATCH_PEN)
               : gap_q    ? SCORE_W'(-GAP_EXT_PEN) : SCORE_W'(-GAP_PEN);
`else
  assign delta = is_match ? SCORE_W'(MATCH_SCORE)
               : is_mis   ? SCORE_W'(-MISMATCH_PEN) : SCORE_W'(-GAP_PEN);
`endif
  score_sat_add #(.W(SCORE_W)) u_add (
    .a_i  (run_q),
    .b_i  (delta),
    .sum_o(run_d)
  );
  assign len_d  = len_q + LEN_W'(1);
  assign best_d = (run_d > best_q) ? run_d : best_q;
  // best_d >= run_d, so the extra bit keeps the difference exact even at saturation
  assign drop   = {best_d[SCORE_W-1], best_d} - {run_d[SCORE_W-1], run_d};
  assign term_d = last ? REASON_LAST
                : (drop > $signed((SCORE_W+1)'(X_DROP))) ? REASON_XDROP
                : (len_d == {LEN_W{1'b1}}) ? REASON_LEN : REASON_NONE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      run_q      <= '0;
      best_q     <= '0;
      len_q      <= '0;
      best_len_q <= '0;
      reason_q   <= REASON_NONE;
      code_err_q <= 1'b0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef SCORER_AFFINE_GAP_EN
      gap_q      <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: if (start) begin
          state_q    <= S_RUN;
          run_q      <= '0;
          best_q     <= '0;
          len_q      <= '0;
          best_len_q <= '0;
          reason_q   <= REASON_NONE;
          code_err_q <= 1'b0;
          in_ready_q <= 1'b1;
          busy_q     <= 1'b1;
`ifdef SCORER_AFFINE_GAP_EN
          gap_q      <= 1'b0;
`endif
        end
        S_RUN: if (accept) begin
          run_q      <= run_d;
          len_q      <= len_d;
          best_q     <= best_d;
          code_err_q <= code_err_q | illegal;
`ifdef SCORER_AFFINE_GAP_EN
          gap_q      <= is_gap;
`endif
          if (run_d > best_q) best_len_q <= len_d;
          if (term_d != REASON_NONE) begin
            state_q    <= S_DONE;
            reason_q   <= term_d;
            in_ready_q <= 1'b0;
            done_q     <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end
  assign in_ready   = in_ready_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign best_score = best_q;
  assign best_len   = best_len_q;
  assign reason     = reason_q;
  assign code_err   = code_err_q;
endmodule
